// File: rtl/cache_fill_arbiter.sv
// Shares one 64-bit memory refill stream between the I-cache and D-cache.
// Fills one line at a time (D before I) and drives the pipeline-wide stall.
module cache_fill_arbiter #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imiss,
  input  logic [ADDR_W-1:0] imiss_addr,
  input  logic              dmiss,
  input  logic [ADDR_W-1:0] dmiss_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              ifill,
  output logic              dfill,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [63:0]       stream,
  output logic              stall,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] beat_cnt;
  logic             fill_beat;

  // Sequencer: arbitrate, request, count beats, one dead cycle, back to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      beat_cnt <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data miss belongs to the older instruction, so it wins.
          if (dmiss) begin
            owner    <= OWN_D;
            mem_addr <= dmiss_addr & LINE_MASK;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end else if (imiss) begin
            owner    <= OWN_I;
            mem_addr <= imiss_addr & LINE_MASK;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req  <= 1'b0;
            beat_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          owner <= OWN_NONE;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat pass-through; a beat arriving in a reset cycle is dropped.
  assign fill_beat = (state == FILL) && mem_rvalid && !reset;
  assign ifill     = fill_beat && (owner == OWN_I);
  assign dfill     = fill_beat && (owner == OWN_D);
  assign stream    = fill_beat ? mem_rdata : 64'd0;
  assign fill_idx  = fill_beat ? IDX_W'(beat_cnt) : '0;

  assign stall = busy || imiss || dmiss;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized bench: caches and memory driven from a transaction-level model
// that also predicts every arbiter output each cycle.
module tb_cache_fill_arbiter;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ADDR_W = 32;
  localparam int          NCYC   = 4000;

  logic              clk = 1'b0;
  logic              reset;
  logic              imiss, dmiss;
  logic [ADDR_W-1:0] imiss_addr, dmiss_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt, mem_rvalid;
  logic [63:0]       mem_rdata;
  logic              ifill, dfill;
  logic [IDX_W-1:0]  fill_idx;
  logic [63:0]       stream;
  logic              stall, busy;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.BEATS(BEATS), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ifill(ifill), .dfill(dfill), .fill_idx(fill_idx), .stream(stream),
    .stall(stall), .busy(busy)
  );

  // Reference: one line transaction in flight, tracked as request/beats-left.
  bit                m_active;
  bit                m_granted;
  int                m_left;
  bit                m_own_d;
  logic [ADDR_W-1:0] m_addr;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a - (a % ADDR_W'(BEATS * 8));
  endfunction

  task automatic start_line(input bit own_d, input logic [ADDR_W-1:0] a);
    m_active  = 1'b1;
    m_granted = 1'b0;
    m_left    = BEATS;
    m_own_d   = own_d;
    m_addr    = line_of(a);
  endtask

  initial begin
    bit in_req, in_fill, in_done, fill_exp;
    reset      = 1'b1;
    imiss      = 1'b1;
    imiss_addr = 32'h0000_0100;
    dmiss      = 1'b1;
    dmiss_addr = 32'h0000_2008;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    m_active   = 1'b0;
    m_granted  = 1'b0;
    m_left     = 0;
    m_own_d    = 1'b0;
    m_addr     = '0;
    @(posedge clk);

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      in_req  = m_active && !m_granted;
      in_fill = m_active && m_granted && (m_left > 0);
      in_done = m_active && m_granted && (m_left == 0);

      reset = (i < 2) || ($urandom_range(0, 149) == 0);

      // Caches hold a miss until their line has streamed in, then drop it.
      if (in_done && !m_own_d) imiss = 1'b0;
      else if (!imiss && $urandom_range(0, 7) == 0) begin
        imiss      = 1'b1;
        imiss_addr = $urandom;
      end
      if (in_done && m_own_d) dmiss = 1'b0;
      else if (!dmiss && $urandom_range(0, 9) == 0) begin
        dmiss      = 1'b1;
        dmiss_addr = $urandom;
      end

      // Memory: random grant latency, bubbled beats, stray beats while idle.
      mem_gnt    = in_req && ($urandom_range(0, 2) == 0);
      mem_rvalid = in_fill ? 1'($urandom_range(0, 1))
                 : (!m_active ? ($urandom_range(0, 3) == 0) : 1'b0);
      mem_rdata  = {$urandom, $urandom};
      #1;

      fill_exp = !reset && in_fill && mem_rvalid;
      check_val("stall",    64'(stall),    64'(m_active || imiss || dmiss));
      check_val("busy",     64'(busy),     64'(m_active));
      check_val("mem_req",  64'(mem_req),  64'(in_req));
      if (in_req) check_val("mem_addr", 64'(mem_addr), 64'(m_addr));
      check_val("ifill",    64'(ifill),    64'(fill_exp && !m_own_d));
      check_val("dfill",    64'(dfill),    64'(fill_exp && m_own_d));
      check_val("fill_idx", 64'(fill_idx), fill_exp ? 64'(BEATS - m_left) : 64'd0);
      check_val("stream",   stream,        fill_exp ? mem_rdata : 64'd0);

      // Advance the reference with the inputs the next clock edge will see.
      if (reset)              m_active = 1'b0;
      else if (!m_active) begin
        if (dmiss)            start_line(1'b1, dmiss_addr);
        else if (imiss)       start_line(1'b0, imiss_addr);
      end
      else if (in_req)  begin if (mem_gnt) m_granted = 1'b1; end
      else if (in_fill) begin if (mem_rvalid) m_left--; end
      else                    m_active = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
